mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 Parameter ADDR_W, default 7, memory word-address width.
- REQ-002 Parameter DATA_W, default 32, memory data width.
- REQ-003 Port CLK  input  1  the single clock; all state changes on rising edge.
- REQ-004 Port RST_N  input  1  reset, asynchronous and active-low.
- REQ-005 Ports P0_REQ / P1_REQ  input  1  access request, requester 0 (CPU) / requester 1 (loader/IO).
- REQ-006 Ports P0_WE / P1_WE  input  1  1=write, 0=read; held with REQ.
- REQ-007 Ports P0_ADDR / P1_ADDR  input  ADDR_W  word address; held with REQ.
- REQ-008 Ports P0_WDATA / P1_WDATA  input  DATA_W  write data; held with REQ.
- REQ-009 Ports P0_ACK / P1_ACK  output  1  one-cycle completion pulse to the granted requester.
- REQ-010 Port RDATA  output  DATA_W  read data captured for the last completed read; valid while ACK is high.
- REQ-011 Ports MEM_CS, MEM_WE  output  1  memory chip select / write enable.
- REQ-012 Port MEM_ADDR  output  ADDR_W  memory address.
- REQ-013 Port MEM_WDATA  output  DATA_W  data driven onto the shared memory bus.
- REQ-014 Port MEM_WDATA_OE  output  1  tri-state enable for MEM_WDATA onto the bus; high only during a write access.
- REQ-015 Port MEM_RDATA  input  DATA_W  shared memory bus as seen by the arbiter.
- REQ-016 Port BUSY  output  1  high while state is ACCESS.

Function
- REQ-017 FSM states: IDLE, ACCESS; all MEM_* outputs, ACK, RDATA and BUSY are registered.
- REQ-018 IDLE: on a rising edge with any REQ high, select a winner, load MEM_ADDR/MEM_WE/MEM_WDATA from it, set MEM_CS=1, set MEM_WDATA_OE=WE, and go to ACCESS.
- REQ-019 IDLE with no REQ: hold MEM_CS=0, MEM_WE=0, MEM_WDATA_OE=0.
- REQ-020 ACCESS lasts exactly one cycle; the memory performs the operation on the falling edge inside it.
- REQ-021 ACCESS exit edge: capture MEM_RDATA into RDATA (reads only; RDATA holds on writes), pulse the winner's ACK for one cycle, clear MEM_CS/MEM_WE/MEM_WDATA_OE, and return to IDLE.
- REQ-022 Latency: REQ sampled at edge k produces ACK high during cycle k+2 to k+3; maximum throughput is one access per 2 cycles.
- REQ-023 A requester shall drop REQ in the cycle its ACK is high; REQ still high at the next edge is a new request.
- REQ-024 REQ deasserted during ACCESS is a protocol violation; the access completes and ACK still pulses.
- REQ-025 The non-granted requester's ACK stays 0; its request remains pending, with no loss and no reordering.
- REQ-026 Both ACKs shall never be high in the same cycle.
- REQ-027 MEM_ADDR/MEM_WDATA pass through unmodified; there is no address translation and no range check.

Reset
- REQ-028 RST_N low immediately forces IDLE, MEM_CS=0, MEM_WE=0, MEM_WDATA_OE=0, MEM_ADDR=0, MEM_WDATA=0, ACK=0, RDATA=0, BUSY=0, and round-robin pointer=1 (port 0 favoured first).
- REQ-029 Reset asserted during ACCESS aborts the access with no ACK; the requester re-requests after release.

Configuration
- REQ-030 Macro MEM_ARB_RR_EN defined: round-robin selection; on simultaneous requests, the port not granted last wins; the pointer updates on each grant.
- REQ-031 Macro MEM_ARB_RR_EN undefined: fixed priority, with port 0 always winning a tie; the pointer logic is absent.

Structure
- REQ-032 Package mem_arb_pkg shall hold the state enum, the default ADDR_W/DATA_W constants, and port-index constants.
- REQ-033 Sub-module mem_arb_pick: combinational winner select from (P0_REQ, P1_REQ, last-grant pointer), honouring MEM_ARB_RR_EN.

Verification
- REQ-034 P0 read, addr 0x05, RAM[5]=0xDEADBEEF -> MEM_CS high one cycle, P0_ACK pulses at k+2, RDATA=0xDEADBEEF.
- REQ-035 P1 write, addr 0x7F, data 0x12345678, then P0 read 0x7F -> MEM_WDATA_OE high only during the write; read returns 0x12345678.
- REQ-036 P0 and P1 both request continuously (RR_EN defined) -> grants alternate P0,P1,P0,P1 for 8 accesses; undefined -> P0 every time, P1 never granted while P0 holds REQ.
- REQ-037 RST_N pulsed low mid-ACCESS -> MEM_CS=0 within the same cycle with no ACK; after release, the pending P1 request is served first (pointer=1 gives port 0 priority only when both request).
- REQ-038 P0 keeps REQ high through its ACK cycle -> a second access is issued at the following edge and ACKs 2 cycles after the first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus memory bus of the arbiter; slave = arbiter view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              P0_REQ, P1_REQ;
    logic              P0_WE, P1_WE;
    logic [ADDR_W-1:0] P0_ADDR, P1_ADDR;
    logic [DATA_W-1:0] P0_WDATA, P1_WDATA;
    logic              P0_ACK, P1_ACK;
    logic [DATA_W-1:0] RDATA;
    logic              MEM_CS, MEM_WE, MEM_WDATA_OE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [DATA_W-1:0] MEM_RDATA;
    logic              BUSY;

    modport slave (
        input  P0_REQ, P1_REQ, P0_WE, P1_WE, P0_ADDR, P1_ADDR,
               P0_WDATA, P1_WDATA, MEM_RDATA,
        output P0_ACK, P1_ACK, RDATA, MEM_CS, MEM_WE, MEM_WDATA_OE,
               MEM_ADDR, MEM_WDATA, BUSY
    );

    modport master (
        output P0_REQ, P1_REQ, P0_WE, P1_WE, P0_ADDR, P1_ADDR,
               P0_WDATA, P1_WDATA, MEM_RDATA,
        input  P0_ACK, P1_ACK, RDATA, MEM_CS, MEM_WE, MEM_WDATA_OE,
               MEM_ADDR, MEM_WDATA, BUSY
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select. MEM_ARB_RR_EN: round-robin on ties using the
// last-granted port; otherwise port 0 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic p0_req_i,
    input  logic p1_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_i,
`endif
    output logic any_o,
    output logic win_o
);

    always_comb begin
        any_o = p0_req_i | p1_req_i;
        win_o = PORT0;
        if (p0_req_i && p1_req_i) begin
`ifdef MEM_ARB_RR_EN
            win_o = (last_i == PORT0) ? PORT1 : PORT0;
`else
            win_o = PORT0;
`endif
        end else if (p1_req_i) begin
            win_o = PORT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: IDLE -> one-cycle ACCESS -> ACK.
// Optional round-robin tie-break enabled by MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    mem_arbiter_if.slave  bus
);

    state_e            state_q;
    logic              win_q;
    logic              cs_q, we_q, oe_q, busy_q;
    logic              ack0_q, ack1_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              any_d, win_d;

`ifdef MEM_ARB_RR_EN
    logic              ptr_q;

    mem_arb_pick u_pick (
        .p0_req_i (bus.P0_REQ),
        .p1_req_i (bus.P1_REQ),
        .last_i   (ptr_q),
        .any_o    (any_d),
        .win_o    (win_d)
    );
`else
    mem_arb_pick u_pick (
        .p0_req_i (bus.P0_REQ),
        .p1_req_i (bus.P1_REQ),
        .any_o    (any_d),
        .win_o    (win_d)
    );
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            win_q   <= PORT0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= PORT1;
`endif
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cs_q <= 1'b0;
                    we_q <= 1'b0;
                    oe_q <= 1'b0;
                    if (any_d) begin
                        state_q <= ST_ACCESS;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b1;
                        win_q   <= win_d;
                        we_q    <= (win_d == PORT1) ? bus.P1_WE    : bus.P0_WE;
                        oe_q    <= (win_d == PORT1) ? bus.P1_WE    : bus.P0_WE;
                        addr_q  <= (win_d == PORT1) ? bus.P1_ADDR  : bus.P0_ADDR;
                        wdata_q <= (win_d == PORT1) ? bus.P1_WDATA : bus.P0_WDATA;
`ifdef MEM_ARB_RR_EN
                        ptr_q   <= win_d;
`endif
                    end
                end
                ST_ACCESS: begin
                    // Memory answered on the falling edge; RDATA only moves on reads.
                    if (!we_q) rdata_q <= bus.MEM_RDATA;
                    ack0_q  <= (win_q == PORT0);
                    ack1_q  <= (win_q == PORT1);
                    cs_q    <= 1'b0;
                    we_q    <= 1'b0;
                    oe_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.MEM_CS       = cs_q;
    assign bus.MEM_WE       = we_q;
    assign bus.MEM_WDATA_OE = oe_q;
    assign bus.MEM_ADDR     = addr_q;
    assign bus.MEM_WDATA    = wdata_q;
    assign bus.RDATA        = rdata_q;
    assign bus.P0_ACK       = ack0_q;
    assign bus.P1_ACK       = ack1_q;
    assign bus.BUSY         = busy_q;

endmodule
